// File: rtl/maze_pkg.sv
// Shared constants and FSM encoding for the maze renderer.
// Included by every maze RTL file that needs grid sizes or state names.
package maze_pkg;
  localparam int MAZE_DIM     = 32;
  localparam int CELL_W       = 5;
  localparam int ADDR_W       = 10;
  localparam int COLOUR_W     = 3;
  localparam int COORD_W      = 10;
  localparam int DEF_CELL_PX  = 3;
  localparam int DEF_X_OFFSET = 32;
  localparam int DEF_Y_OFFSET = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DRAW,
    ST_DONE
  } state_t;
endpackage

// File: rtl/maze_cell_scanner.sv
// Raster-order cell counter for the maze grid: clear, advance with row wrap,
// and a flag marking the final cell of the grid.
module maze_cell_scanner
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              inc,
  output logic [CELL_W-1:0] cell_x,
  output logic [CELL_W-1:0] cell_y,
  output logic [CELL_W-1:0] next_x,
  output logic [CELL_W-1:0] next_y,
  output logic              last_cell
);
  localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(MAZE_DIM - 1);

  logic [CELL_W-1:0] cell_x_q, cell_x_d;
  logic [CELL_W-1:0] cell_y_q, cell_y_d;

  always_comb begin
    next_x   = (cell_x_q == CELL_MAX) ? '0 : cell_x_q + 1'b1;
    next_y   = (cell_x_q == CELL_MAX) ? cell_y_q + 1'b1 : cell_y_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    if (clr) begin
      cell_x_d = '0;
      cell_y_d = '0;
    end else if (inc) begin
      cell_x_d = next_x;
      cell_y_d = next_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cell_x_q <= '0;
      cell_y_q <= '0;
    end else begin
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
    end
  end

  assign cell_x    = cell_x_q;
  assign cell_y    = cell_y_q;
  assign last_cell = (cell_x_q == CELL_MAX) && (cell_y_q == CELL_MAX);
endmodule

// File: rtl/draw_maze_vga.sv
// Redraws the whole maze to a VGA adapter: per cell, read mazeRAM, wait one
// cycle for data, then plot a CELL_PX x CELL_PX square; all outputs registered.
module draw_maze_vga
  import maze_pkg::*;
#(
  parameter int CELL_PX  = DEF_CELL_PX,
  parameter int X_OFFSET = DEF_X_OFFSET,
  parameter int Y_OFFSET = DEF_Y_OFFSET
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic [9:0]    ram_address,
  input  logic [2:0]    ram_q,
  output logic [7:0]    vga_x,
  output logic [6:0]    vga_y,
  output logic [2:0]    vga_colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);
  localparam int PX_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_PX - 1);

  state_t                state_q, state_d;
  logic [PX_W-1:0]       px_q, px_d, py_q, py_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic [ADDR_W-1:0]     ram_address_q, ram_address_d;
  logic [7:0]            vga_x_q, vga_x_d;
  logic [6:0]            vga_y_q, vga_y_d;
  logic                  plot_q, plot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  scan_clr, scan_inc, last_cell;
  logic [CELL_W-1:0]     cell_x, cell_y, next_x, next_y;
  logic [COORD_W-1:0]    base_x, base_y, pix_x, pix_y;

  maze_cell_scanner u_scanner (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (scan_clr),
    .inc       (scan_inc),
    .cell_x    (cell_x),
    .cell_y    (cell_y),
    .next_x    (next_x),
    .next_y    (next_y),
    .last_cell (last_cell)
  );

  // Cell origin on screen; kept wide so the truncation happens only at the ports.
  assign base_x = COORD_W'(X_OFFSET) + COORD_W'(CELL_PX) * COORD_W'(cell_x);
  assign base_y = COORD_W'(Y_OFFSET) + COORD_W'(CELL_PX) * COORD_W'(cell_y);

  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    colour_d      = colour_q;
    ram_address_d = ram_address_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    plot_d        = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    scan_clr      = 1'b0;
    scan_inc      = 1'b0;
    pix_x         = base_x;
    pix_y         = base_y;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_READ;
          scan_clr      = 1'b1;
          px_d          = '0;
          py_d          = '0;
          ram_address_d = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d  = ST_DRAW;
        colour_d = ram_q;
        plot_d   = 1'b1;
        px_d     = '0;
        py_d     = '0;
      end
      ST_DRAW: begin
        if (px_q != PX_LAST) begin
          px_d   = px_q + 1'b1;
          plot_d = 1'b1;
        end else if (py_q != PX_LAST) begin
          px_d   = '0;
          py_d   = py_q + 1'b1;
          plot_d = 1'b1;
        end else begin
          px_d = '0;
          py_d = '0;
          if (last_cell) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d       = ST_READ;
            scan_inc      = 1'b1;
            ram_address_d = {next_y, next_x};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pixel coordinates follow the pixel counters of the cycle being plotted.
    if (plot_d) begin
      pix_x   = base_x + COORD_W'(px_d);
      pix_y   = base_y + COORD_W'(py_d);
      vga_x_d = pix_x[7:0];
      vga_y_d = pix_y[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      px_q          <= '0;
      py_q          <= '0;
      colour_q      <= '0;
      ram_address_q <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      colour_q      <= colour_d;
      ram_address_q <= ram_address_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ram_address = ram_address_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = colour_q;
  assign plot        = plot_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: doc/draw_maze_vga.md
DRAW_MAZE_VGA -- requirements
Module: draw_maze_vga

Interface
REQ-001 Parameter CELL_PX, default 3: pixel edge length of one maze cell on screen.
REQ-002 Parameter X_OFFSET, default 32: screen x of the left edge of cell (0,0).
REQ-003 Parameter Y_OFFSET, default 12: screen y of the top edge of cell (0,0).
REQ-004 clk  in  1  clock; all logic on posedge clk.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  level; sampled only in IDLE or DONE; begins one full maze redraw.
REQ-007 ram_address  out  10  mazeRAM read address, {cell_y[4:0], cell_x[4:0]}.
REQ-008 ram_q  in  3  mazeRAM read data; valid one cycle after ram_address is presented.
REQ-009 vga_x  out  8  VGA adapter pixel x.
REQ-010 vga_y  out  7  VGA adapter pixel y.
REQ-011 vga_colour  out  3  VGA adapter RGB colour.
REQ-012 plot  out  1  VGA adapter write enable; one pixel written per cycle it is high.
REQ-013 busy  out  1  high from the cycle after start is accepted until done rises.
REQ-014 done  out  1  level; high after a complete redraw until the next accepted start or reset.

Function
REQ-015 FSM states: IDLE, READ, WAIT, DRAW, DONE.
REQ-016 IDLE/DONE with start=1 -> READ on the next edge; cell_x, cell_y, px, py cleared; done cleared on the same edge.
REQ-017 READ: ram_address = {cell_y, cell_x}; -> WAIT.
REQ-018 WAIT: ram_address held; at the end of the cycle ram_q is latched into a colour register; -> DRAW.
REQ-019 DRAW: plot=1 for exactly CELL_PX*CELL_PX consecutive cycles.
REQ-020 DRAW pixel order: px increments fastest (0..CELL_PX-1), then py.
REQ-021 DRAW outputs: vga_x = X_OFFSET + CELL_PX*cell_x + px; vga_y = Y_OFFSET + CELL_PX*cell_y + py; vga_colour = latched colour.
REQ-022 After the last pixel of a cell: cell_x increments, wrapping 31->0 with cell_y+1, and state -> READ.
REQ-023 If the last pixel of cell (31,31) has been drawn, state -> DONE instead of READ; done=1 and busy=0 from that edge.
REQ-024 Cost per cell is CELL_PX*CELL_PX+2 cycles (11 at default); one redraw produces exactly 1024*CELL_PX*CELL_PX plot cycles (9216 at default).
REQ-025 Cells are visited in raster order, address 0..1023 ascending, each exactly once per redraw.
REQ-026 Coordinate arithmetic is at least 10 bits wide internally, truncated to 8/7 bits at the outputs; defaults never exceed x=127, y=107.
REQ-027 start is ignored in READ, WAIT and DRAW; the redraw is not restarted.
REQ-028 plot=0 in every state except DRAW; vga_x, vga_y and vga_colour are don't-care when plot=0, but are driven to stable, non-X values.
REQ-029 The block never writes mazeRAM; it is read-only with respect to the maze.

Reset
REQ-030 resetn=0 at an edge: state=IDLE; cell_x, cell_y, px, py, colour register=0; ram_address=0; plot=0; busy=0; done=0.
REQ-031 Reset asserted mid-redraw aborts immediately, with no further plot cycles; a later start redraws from cell (0,0).
REQ-032 resetn has priority over start on the same edge.

Structure
REQ-033 A shared package maze_pkg holds MAZE_DIM=32, the address width 10, the colour width 3, the default CELL_PX/X_OFFSET/Y_OFFSET values and the FSM state enumeration.
REQ-034 One sub-module, maze_cell_scanner, owns the cell_x/cell_y counters, the wrap logic and the last-cell flag; the FSM and the pixel counters remain in draw_maze_vga.

Verification
REQ-035 Reset, then start=1 for one cycle with the RAM model all zero -> 9216 plot cycles; done rises 11*1024 cycles after READ is first entered; busy is low once done is high.
REQ-036 RAM model with address 0 = 3'b100 and address 1023 = 3'b010 -> the first 9 plots are at x 32..34, y 12..14 with colour 4; the last 9 plots are at x 125..127, y 105..107 with colour 2.
REQ-037 RAM with address 33 = 3'b111 -> cell (1,1) plots at x 35..37, y 15..17 with colour 7, in px-fastest order.
REQ-038 start held high for the whole redraw -> exactly one redraw completes, and a second redraw begins the edge after DONE is entered with done cleared.
REQ-039 resetn pulsed low for one cycle during DRAW of cell 500 -> plot is 0 from the next edge; a following start redraws from address 0 with a full 9216-plot count.
REQ-040 Scoreboard on every run: each address 0..1023 is read exactly once, in ascending order, and every plotted pixel lies inside x 32..127, y 12..107.
